mine_ctrl: RTL and testbench
============================

Name: mine_ctrl

Overview:
- Game sequencer for the minesweeper datapath `dp`.
- Accepts player guesses over a valid/ready handshake and screens out invalid or repeated cells.
- Drives the datapath control levels (start, load, decode, alu) in order and waits for each done flag, with a timeout on every wait.
- Resolves each move from the datapath gameover/win flags into WON, LOST or the next guess; keeps a move counter.

Parameters:
- NUM_CELLS, 25, number of board cells; a guess is valid only if guess < NUM_CELLS.
- TIMEOUT, 16, maximum cycles to wait for a done flag before entering ERR.
- CNT_W, 8, width of move_count.

Ports:
- clka  in  1  single system clock; all state updates on rising edge.
- restart  in  1  synchronous active-high reset.
- start_btn  in  1  request a new game; sampled in IDLE, WON, LOST.
- guess_valid  in  1  player guess present.
- guess  in  5  encoded cell index.
- guess_ready  out  1  high only in WAIT_GUESS.
- guess_reject  out  1  one-cycle pulse when a presented guess is discarded.
- place_done  in  1  datapath mine placement complete.
- decode_done  in  1  datapath decode complete.
- alu_done  in  1  datapath ALU update complete.
- gameover  in  1  datapath mine-hit/end flag.
- win  in  1  datapath win flag.
- start  out  1  datapath start level.
- load  out  1  datapath load level.
- decode  out  1  datapath decode level.
- alu  out  1  datapath alu level.
- data  out  5  guess index to the datapath; valid while load is high.
- game_won  out  1  high while in WON.
- game_lost  out  1  high while in LOST.
- err  out  1  high while in ERR.
- move_count  out  CNT_W  accepted moves this game.

Behaviour:
- Reset (restart=1, takes priority in every state):
  - state=IDLE; all outputs 0; move_count=0; timeout counter=0; internal 25-bit shadow cleared mask=0.
- Control levels are one-hot:
  - At most one of start/load/decode/alu is high in any cycle.
  - Each level is a registered decode of the state.
- States and transitions:
  - IDLE: start_btn -> PLACE. Clear the shadow mask and move_count on that transition.
  - PLACE: start=1. place_done -> WAIT_GUESS.
  - WAIT_GUESS: guess_ready=1. When guess_valid is high:
    - Reject if guess >= NUM_CELLS or mask[guess]=1: pulse guess_reject for one cycle, stay in WAIT_GUESS.
    - Otherwise accept: latch guess into data, -> LOAD.
  - LOAD: load=1 for exactly one cycle (no done flag) -> DECODE.
  - DECODE: decode=1. decode_done -> ALU.
  - ALU: alu=1. alu_done -> CHECK. On that transition:
    - set mask[data];
    - increment move_count, saturating at all-ones.
  - CHECK: one cycle; samples the datapath flags with this priority:
    - win=1 -> WON (win beats gameover, because the datapath also raises gameover on a win);
    - else gameover=1 -> LOST;
    - else -> WAIT_GUESS.
  - WON / LOST: hold the flag. start_btn -> PLACE, clearing the mask and move_count.
  - ERR: err=1, all control levels 0. Exit only via restart.
- Timeout:
  - The counter clears on entry to PLACE, DECODE or ALU and increments each cycle while the done flag is low.
  - Done seen in the same cycle the counter reaches TIMEOUT-1: done wins, no ERR.
  - Otherwise reaching TIMEOUT-1 -> ERR on the next edge.
- Handshake rules:
  - A guess transfers only when guess_valid and guess_ready are both high in the same cycle.
  - A guess presented outside WAIT_GUESS is ignored (no reject pulse).
  - data holds its value until the next accepted guess.
  - A done flag that is already high on entry to its wait state advances after one cycle (level-sensitive).
  - Done flags arriving in any other state are ignored.
- start_btn outside IDLE/WON/LOST is ignored.
- Restart mid-move (e.g. in DECODE) drops decode the next cycle. move_count and the mask do not advance.
- Per-move latency with immediate done flags: accept -> LOAD -> DECODE -> ALU -> CHECK. Next guess_ready comes 5 cycles after acceptance.

Test Plan:
- Restart, start_btn, place_done after 2 cycles -> start high 3 cycles, then guess_ready=1; move_count=0.
- Guess 7 with immediate dones, gameover=0, win=0 -> data=7, load high 1 cycle, decode then alu, move_count=1, back in WAIT_GUESS 5 cycles after accept.
- Repeat guess 7, then guess 25 -> guess_reject pulses twice, no load, move_count stays 1.
- Guess hitting a mine (gameover=1, win=0) -> LOST, game_lost=1. start_btn -> PLACE, move_count=0, guess 7 accepted again.
- Final clearing guess with gameover=1 and win=1 -> WON, game_won=1, game_lost=0.
- decode_done held low 16 cycles -> err=1, control levels 0, guess_ready=0. restart -> IDLE, all outputs 0.

Source files
------------

// File: rtl/mine_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mine_ctrl
//  Brief    : Minesweeper game sequencer. Screens player guesses, steps the
//             datapath through start/load/decode/alu with per-wait timeouts,
//             and resolves each move into WON, LOST or the next guess.
//  Revision : 1.0  initial release
// ============================================================================
module mine_ctrl #(
  parameter int NUM_CELLS = 25,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clka,
  input  logic             restart,
  input  logic             start_btn,
  input  logic             guess_valid,
  input  logic [4:0]       guess,
  output logic             guess_ready,
  output logic             guess_reject,
  input  logic             place_done,
  input  logic             decode_done,
  input  logic             alu_done,
  input  logic             gameover,
  input  logic             win,
  output logic             start,
  output logic             load,
  output logic             decode,
  output logic             alu,
  output logic [4:0]       data,
  output logic             game_won,
  output logic             game_lost,
  output logic             err,
  output logic [CNT_W-1:0] move_count
);

  // Counter must be able to hold TIMEOUT-1; one spare code keeps it safe.
  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  // A 5-bit guess addresses up to 32 cells; the mask is zero-padded to that
  // range so out-of-board indices read as "not yet guessed".
  localparam int               MASK_W   = 32;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_PLACE      = 4'd1,
    S_WAIT_GUESS = 4'd2,
    S_LOAD       = 4'd3,
    S_DECODE     = 4'd4,
    S_ALU        = 4'd5,
    S_CHECK      = 4'd6,
    S_WON        = 4'd7,
    S_LOST       = 4'd8,
    S_ERR        = 4'd9
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_CELLS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [4:0]           data_q, data_d;
  logic                 reject_d;

  logic ready_q, reject_q, start_q, load_q, decode_q, alu_q;
  logic won_q, lost_q, err_q;

  logic [MASK_W-1:0]    w_mask_ext;
  logic                 w_guess_bad;
  logic                 w_tmo_hit;

  assign w_mask_ext  = MASK_W'(mask_q);
  assign w_guess_bad = (32'(guess) >= NUM_CELLS) || w_mask_ext[guess];
  assign w_tmo_hit   = (tmo_q == TMO_LAST);

  // Next-state, datapath bookkeeping and timeout handling.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    reject_d = 1'b0;

    case (state_q)
      S_IDLE, S_WON, S_LOST: begin
        if (start_btn) begin
          state_d = S_PLACE;
          mask_d  = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end

      S_PLACE: begin
        if (place_done) begin
          state_d = S_WAIT_GUESS;
        end else if (w_tmo_hit) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_WAIT_GUESS: begin
        if (guess_valid) begin
          if (w_guess_bad) begin
            reject_d = 1'b1;
          end else begin
            data_d  = guess;
            state_d = S_LOAD;
          end
        end
      end

      // Load has no handshake: a single cycle, then arm the decode timeout.
      S_LOAD: begin
        state_d = S_DECODE;
        tmo_d   = '0;
      end

      S_DECODE: begin
        if (decode_done) begin
          state_d = S_ALU;
          tmo_d   = '0;
        end else if (w_tmo_hit) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_ALU: begin
        if (alu_done) begin
          state_d = S_CHECK;
          mask_d  = mask_q | NUM_CELLS'(MASK_W'(1) << data_q);
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (w_tmo_hit) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      // The datapath raises gameover on a win as well, so win is tested first.
      S_CHECK: begin
        if (win) begin
          state_d = S_WON;
        end else if (gameover) begin
          state_d = S_LOST;
        end else begin
          state_d = S_WAIT_GUESS;
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered output decode of the next state.
  always_ff @(posedge clka) begin
    if (restart) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      reject_q <= 1'b0;
      start_q  <= 1'b0;
      load_q   <= 1'b0;
      decode_q <= 1'b0;
      alu_q    <= 1'b0;
      won_q    <= 1'b0;
      lost_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      ready_q  <= (state_d == S_WAIT_GUESS);
      reject_q <= reject_d;
      start_q  <= (state_d == S_PLACE);
      load_q   <= (state_d == S_LOAD);
      decode_q <= (state_d == S_DECODE);
      alu_q    <= (state_d == S_ALU);
      won_q    <= (state_d == S_WON);
      lost_q   <= (state_d == S_LOST);
      err_q    <= (state_d == S_ERR);
    end
  end

  assign guess_ready  = ready_q;
  assign guess_reject = reject_q;
  assign start        = start_q;
  assign load         = load_q;
  assign decode       = decode_q;
  assign alu          = alu_q;
  assign data         = data_q;
  assign game_won     = won_q;
  assign game_lost    = lost_q;
  assign err          = err_q;
  assign move_count   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mine_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mine_ctrl
//  Brief    : Self-checking bench for mine_ctrl: directed vector table, hand
//             sequences for timeout/restart, and randomized games scored
//             against a move-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mine_ctrl;

  localparam int NUM_CELLS = 25;
  localparam int TIMEOUT   = 16;
  localparam int CNT_W     = 8;

  logic             clka;
  logic             restart;
  logic             start_btn;
  logic             guess_valid;
  logic [4:0]       guess;
  logic             guess_ready;
  logic             guess_reject;
  logic             place_done;
  logic             decode_done;
  logic             alu_done;
  logic             gameover;
  logic             win;
  logic             start;
  logic             load;
  logic             decode;
  logic             alu;
  logic [4:0]       data;
  logic             game_won;
  logic             game_lost;
  logic             err;
  logic [CNT_W-1:0] move_count;

  mine_ctrl #(
    .NUM_CELLS (NUM_CELLS),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clka         (clka),
    .restart      (restart),
    .start_btn    (start_btn),
    .guess_valid  (guess_valid),
    .guess        (guess),
    .guess_ready  (guess_ready),
    .guess_reject (guess_reject),
    .place_done   (place_done),
    .decode_done  (decode_done),
    .alu_done     (alu_done),
    .gameover     (gameover),
    .win          (win),
    .start        (start),
    .load         (load),
    .decode       (decode),
    .alu          (alu),
    .data         (data),
    .game_won     (game_won),
    .game_lost    (game_lost),
    .err          (err),
    .move_count   (move_count)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  int n_total = 0;
  int n_pass  = 0;

  // Result codes for a resolved move.
  localparam int R_NEXT = 0;
  localparam int R_WON  = 1;
  localparam int R_LOST = 2;

  typedef struct {
    bit         ng;     // start a new game before this row
    logic [4:0] g;
    int         dd;     // cycles decode_done is held low
    int         ad;     // cycles alu_done is held low
    bit         w;
    bit         go;
    bit         acc;    // expected to be accepted
    int         cnt;    // move_count after the row
    int         res;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_levels"}, 32'({start, load, decode, alu}), 0);
    chk({tag, "_flags"}, 32'({guess_ready, guess_reject, game_won, game_lost, err}), 0);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_cnt"}, 32'(move_count), 0);
  endtask

  task automatic do_restart();
    restart     = 1'b1;
    start_btn   = 1'b0;
    guess_valid = 1'b0;
    guess       = '0;
    place_done  = 1'b0;
    decode_done = 1'b0;
    alu_done    = 1'b0;
    gameover    = 1'b0;
    win         = 1'b0;
    tick();
    tick();
    restart = 1'b0;
    check_all_zero("rst");
  endtask

  // From IDLE/WON/LOST: press start, hold place_done low for pd cycles.
  task automatic start_game(input int pd);
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    chk("sg_cnt_clear", 32'(move_count), 0);
    chk("sg_flags_clear", 32'({game_won, game_lost, guess_ready}), 0);
    for (int k = 0; k <= pd; k++) begin
      chk("sg_start", 32'({start, load, decode, alu}), 32'b1000);
      place_done = (k == pd);
      tick();
    end
    place_done = 1'b0;
    chk("sg_start_drop", 32'(start), 0);
    chk("sg_ready", 32'(guess_ready), 1);
  endtask

  // In WAIT_GUESS: present a guess that must be discarded.
  task automatic present_reject(input logic [4:0] g);
    guess_valid = 1'b1;
    guess       = g;
    tick();
    guess_valid = 1'b0;
    chk("rej_pulse", 32'(guess_reject), 1);
    chk("rej_stay", 32'({guess_ready, load}), 32'b10);
    tick();
    chk("rej_one_cycle", 32'(guess_reject), 0);
    chk("rej_ready", 32'(guess_ready), 1);
  endtask

  // In WAIT_GUESS: present an acceptable guess and walk the whole move.
  // While busy, junk guesses/start presses/place_done must be ignored.
  task automatic run_move(input logic [4:0] g, input int dd, input int ad,
                          input bit w, input bit go, input int exp_cnt, input int exp_res);
    guess_valid = 1'b1;
    guess       = g;
    win         = w;
    gameover    = go;
    decode_done = 1'b0;
    alu_done    = 1'b0;
    tick();
    chk("mv_load", 32'({start, load, decode, alu}), 32'b0100);
    chk("mv_data", 32'(data), 32'(g));
    chk("mv_ready_low", 32'(guess_ready), 0);
    chk("mv_no_reject", 32'(guess_reject), 0);
    guess      = 5'd31;
    start_btn  = 1'b1;
    place_done = 1'b1;
    tick();
    for (int k = 0; k <= dd; k++) begin
      chk("mv_decode", 32'({start, load, decode, alu}), 32'b0010);
      decode_done = (k == dd);
      tick();
    end
    decode_done = 1'b0;
    for (int k = 0; k <= ad; k++) begin
      chk("mv_alu", 32'({start, load, decode, alu, err}), 32'b00010);
      chk("mv_cnt_pre", 32'(move_count), 32'(exp_cnt - 1));
      alu_done = (k == ad);
      tick();
    end
    alu_done = 1'b0;
    chk("mv_check_idle", 32'({start, load, decode, alu, guess_ready}), 0);
    chk("mv_cnt", 32'(move_count), 32'(exp_cnt));
    chk("mv_busy_no_reject", 32'(guess_reject), 0);
    chk("mv_data_hold", 32'(data), 32'(g));
    guess_valid = 1'b0;
    start_btn   = 1'b0;
    place_done  = 1'b0;
    tick();
    win      = 1'b0;
    gameover = 1'b0;
    case (exp_res)
      R_WON:   chk("mv_result", 32'({game_won, game_lost, guess_ready}), 32'b100);
      R_LOST:  chk("mv_result", 32'({game_won, game_lost, guess_ready}), 32'b010);
      default: chk("mv_result", 32'({game_won, game_lost, guess_ready}), 32'b001);
    endcase
    chk("mv_err", 32'(err), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen [int];
    int hist [$];
    int cnt;
    int res;
    int g;
    bit w;
    bit go;

    //           ng  g      dd  ad  w  go acc cnt res
    vecs[0] = '{0, 5'd7,  0,  0,  0, 0, 1,  1,  R_NEXT};
    vecs[1] = '{0, 5'd7,  0,  0,  0, 0, 0,  1,  R_NEXT};
    vecs[2] = '{0, 5'd25, 0,  0,  0, 0, 0,  1,  R_NEXT};
    vecs[3] = '{0, 5'd31, 0,  0,  0, 0, 0,  1,  R_NEXT};
    vecs[4] = '{0, 5'd24, 15, 0,  0, 0, 1,  2,  R_NEXT};
    vecs[5] = '{0, 5'd0,  0,  15, 0, 0, 1,  3,  R_NEXT};
    vecs[6] = '{0, 5'd3,  2,  1,  0, 1, 1,  4,  R_LOST};
    vecs[7] = '{1, 5'd7,  0,  0,  0, 0, 1,  1,  R_NEXT};
    vecs[8] = '{0, 5'd12, 0,  0,  1, 1, 1,  2,  R_WON};

    do_restart();

    // New game with place_done two cycles late: start high three cycles.
    start_game(2);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].ng) start_game(0);
      if (vecs[i].acc) begin
        run_move(vecs[i].g, vecs[i].dd, vecs[i].ad, vecs[i].w, vecs[i].go,
                 vecs[i].cnt, vecs[i].res);
      end else begin
        present_reject(vecs[i].g);
        chk("vec_cnt_hold", 32'(move_count), 32'(vecs[i].cnt));
      end
    end

    // Decode never completes: sixteen decode cycles, then ERR.
    do_restart();
    start_game(0);
    guess_valid = 1'b1;
    guess       = 5'd1;
    tick();
    guess_valid = 1'b0;
    tick();
    for (int k = 0; k < TIMEOUT; k++) begin
      chk("to_decode", 32'({decode, err}), 32'b10);
      tick();
    end
    chk("to_err", 32'(err), 1);
    chk("to_levels", 32'({start, load, decode, alu}), 0);
    chk("to_ready", 32'(guess_ready), 0);
    start_btn   = 1'b1;
    decode_done = 1'b1;
    tick();
    start_btn   = 1'b0;
    decode_done = 1'b0;
    chk("to_err_sticky", 32'({err, start}), 32'b10);
    do_restart();

    // Restart while decode_done arrives: move_count must not advance.
    start_game(1);
    run_move(5'd5, 0, 0, 0, 0, 1, R_NEXT);
    guess_valid = 1'b1;
    guess       = 5'd6;
    tick();
    guess_valid = 1'b0;
    tick();
    chk("rm_decode", 32'(decode), 1);
    restart     = 1'b1;
    decode_done = 1'b1;
    alu_done    = 1'b1;
    tick();
    chk("rm_drop", 32'({decode, alu}), 0);
    chk("rm_cnt", 32'(move_count), 0);
    restart     = 1'b0;
    decode_done = 1'b0;
    alu_done    = 1'b0;
    start_game(0);
    run_move(5'd5, 0, 0, 0, 0, 1, R_NEXT);

    // Randomized games against a move-level model.
    do_restart();
    for (int game = 0; game < 6; game++) begin
      start_game(int'($urandom_range(0, 4)));
      seen.delete();
      hist.delete();
      cnt = 0;
      res = R_NEXT;
      for (int mv = 0; mv < 30 && res == R_NEXT; mv++) begin
        if (hist.size() > 0 && $urandom_range(0, 3) == 0)
          g = hist[$urandom_range(0, hist.size() - 1)];
        else
          g = int'($urandom_range(0, 31));
        if (g >= NUM_CELLS || seen.exists(g)) begin
          present_reject(5'(g));
          chk("rnd_cnt_hold", 32'(move_count), 32'(cnt));
        end else begin
          w  = ($urandom_range(0, 9) == 0);
          go = ($urandom_range(0, 6) == 0);
          seen[g] = 1'b1;
          hist.push_back(g);
          cnt = (cnt < (1 << CNT_W) - 1) ? cnt + 1 : cnt;
          res = w ? R_WON : (go ? R_LOST : R_NEXT);
          run_move(5'(g), int'($urandom_range(0, TIMEOUT - 1)),
                   int'($urandom_range(0, TIMEOUT - 1)), w, go, cnt, res);
        end
      end
      if (res == R_NEXT) do_restart();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
